// File: rtl/tx_sched_pkg.sv
// Shared types and sizes for the frame transmit scheduler.
package tx_sched_pkg;

    localparam int PAYLOAD_W = 44;
    localparam int NUM_REQ   = 2;

    typedef logic [PAYLOAD_W-1:0] payload_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } sched_state_e;

endpackage

// File: rtl/tx_scheduler_if.sv
// Requester and serializer signals of the transmit scheduler.
// The scheduler uses master; requesters and the serializer use slave.
interface tx_scheduler_if;
    import tx_sched_pkg::*;

    logic [NUM_REQ-1:0] req_valid;
    payload_t           req_payload0;
    payload_t           req_payload1;
    logic [NUM_REQ-1:0] req_ready;
    logic               tx_start;
    payload_t           tx_payload;
    logic               tx_src;
    logic               tx_done;
    logic               timeout_err;
    logic [15:0]        frames_sent;
    logic               sched_idle;

    modport master (
        input  req_valid, req_payload0, req_payload1, tx_done,
        output req_ready, tx_start, tx_payload, tx_src, timeout_err, frames_sent, sched_idle
    );

    modport slave (
        output req_valid, req_payload0, req_payload1, tx_done,
        input  req_ready, tx_start, tx_payload, tx_src, timeout_err, frames_sent, sched_idle
    );

endinterface

// File: rtl/tx_rr_arbiter.sv
// Two-way round-robin arbiter: one-hot grant plus the index of the winner.
module tx_rr_arbiter
    import tx_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_idx
);

    // On contention the requester not served last wins; otherwise the lone requester.
    always_comb begin
        grant     = 2'b00;
        grant_idx = 1'b0;
        case (req)
            2'b01: begin
                grant     = 2'b01;
                grant_idx = 1'b0;
            end
            2'b10: begin
                grant     = 2'b10;
                grant_idx = 1'b1;
            end
            2'b11: begin
                grant     = last ? 2'b01 : 2'b10;
                grant_idx = ~last;
            end
            default: begin
                grant     = 2'b00;
                grant_idx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/tx_scheduler.sv
// Frame transmit scheduler: round-robin grant of two requesters, one frame in
// flight, serializer timeout supervision and inter-frame gap enforcement.
module tx_scheduler
    import tx_sched_pkg::*;
#(
    parameter int IFG_CYCLES = 48,
    parameter int TX_TIMEOUT = 1024
) (
    input  logic           eth_clk,
    input  logic           eth_rst_n,
    tx_scheduler_if.master bus
);

    localparam int WAIT_W = $clog2(TX_TIMEOUT + 1);
    localparam int GAP_W  = $clog2(IFG_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TX_TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(IFG_CYCLES - 1);

    logic [1:0]         rst_sync_r;
    logic               rst_n_s;
    sched_state_e       state_r;
    sched_state_e       state_next_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic               last_r;
    payload_t           tx_payload_r;
    logic               tx_src_r;
    logic               timeout_err_r;
    logic [15:0]        frames_sent_r;
    logic               tx_start_r;
    logic               sched_idle_r;
    logic [NUM_REQ-1:0] grant_s;
    logic               grant_idx_s;
    logic [NUM_REQ-1:0] req_ready_s;
    logic               tx_start_next_s;
    logic               sched_idle_next_s;
    logic               handshake_s;
    logic               done_s;
    logic               timeout_s;

    tx_rr_arbiter u_arb (
        .req       (bus.req_valid),
        .last      (last_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // tx_done takes precedence over a timeout landing in the same cycle.
    assign handshake_s = |(bus.req_valid & req_ready_s);
    assign done_s      = (state_r == WAIT_DONE) && bus.tx_done;
    assign timeout_s   = (state_r == WAIT_DONE) && !bus.tx_done && (wait_cnt_r == WAIT_LAST);
    assign rst_n_s     = rst_sync_r[1];

    // Reset synchronizer: asserts immediately, releases two edges after eth_rst_n rises.
    always_ff @(posedge eth_clk or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    // FSM state register.
    always_ff @(posedge eth_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (handshake_s) state_next_s = START;
                else             state_next_s = IDLE;
            end
            START: state_next_s = WAIT_DONE;
            WAIT_DONE: begin
                if (done_s || timeout_s) state_next_s = GAP;
                else                     state_next_s = WAIT_DONE;
            end
            GAP: begin
                if (gap_cnt_r == {GAP_W{1'b0}}) state_next_s = IDLE;
                else                            state_next_s = GAP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: grant is live only in IDLE; pulse/idle flags are pre-decoded for registering.
    always_comb begin
        req_ready_s       = {NUM_REQ{1'b0}};
        tx_start_next_s   = 1'b0;
        sched_idle_next_s = 1'b0;
        if (state_r == IDLE) req_ready_s = grant_s;
        else                 req_ready_s = {NUM_REQ{1'b0}};
        case (state_next_s)
            IDLE:    sched_idle_next_s = 1'b1;
            START:   tx_start_next_s   = 1'b1;
            default: begin
                tx_start_next_s   = 1'b0;
                sched_idle_next_s = 1'b0;
            end
        endcase
    end

    // Registered status flags, grant capture, pointer and frame counter.
    always_ff @(posedge eth_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            tx_start_r    <= 1'b0;
            sched_idle_r  <= 1'b1;
            timeout_err_r <= 1'b0;
            tx_payload_r  <= {PAYLOAD_W{1'b0}};
            tx_src_r      <= 1'b0;
            last_r        <= 1'b1;
            frames_sent_r <= 16'h0000;
        end else begin
            tx_start_r    <= tx_start_next_s;
            sched_idle_r  <= sched_idle_next_s;
            timeout_err_r <= timeout_s;
            if (handshake_s) begin
                tx_payload_r <= grant_idx_s ? bus.req_payload1 : bus.req_payload0;
                tx_src_r     <= grant_idx_s;
                last_r       <= grant_idx_s;
            end else begin
                tx_payload_r <= tx_payload_r;
                tx_src_r     <= tx_src_r;
                last_r       <= last_r;
            end
            if (done_s) frames_sent_r <= frames_sent_r + 16'd1;
            else        frames_sent_r <= frames_sent_r;
        end
    end

    // Serializer watchdog: counts WAIT_DONE cycles from zero.
    always_ff @(posedge eth_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (state_r == WAIT_DONE) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end
    end

    // Gap counter: loaded as the frame ends, counts down to zero through GAP.
    always_ff @(posedge eth_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            gap_cnt_r <= {GAP_W{1'b0}};
        end else if (done_s || timeout_s) begin
            gap_cnt_r <= GAP_LOAD;
        end else if ((state_r == GAP) && (gap_cnt_r != {GAP_W{1'b0}})) begin
            gap_cnt_r <= gap_cnt_r - GAP_W'(1);
        end else begin
            gap_cnt_r <= gap_cnt_r;
        end
    end

    assign bus.req_ready   = req_ready_s;
    assign bus.tx_start    = tx_start_r;
    assign bus.tx_payload  = tx_payload_r;
    assign bus.tx_src      = tx_src_r;
    assign bus.timeout_err = timeout_err_r;
    assign bus.frames_sent = frames_sent_r;
    assign bus.sched_idle  = sched_idle_r;

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed self-checking bench for tx_scheduler with a grant scoreboard.
module tb_tx_scheduler;
    import tx_sched_pkg::*;

    typedef struct packed {
        logic     src;
        payload_t payload;
    } exp_t;

    localparam payload_t P_A = 44'h123456789AB;
    localparam payload_t P_B = 44'hB0B0B0B0B0B;
    localparam payload_t P_C = 44'hC0FFEE00C01;
    localparam payload_t P_D = 44'hD00DFEED0D2;
    localparam payload_t P_E = 44'hE1E2E3E4E5E;
    localparam payload_t P_F = 44'hF0F0F0F0F0F;
    localparam payload_t P_G = 44'h0A0B0C0D0E0;
    localparam payload_t P_H = 44'h5A5A5A5A5A5;
    localparam payload_t P_I = 44'hA5A5A5A5A5A;

    logic eth_clk = 1'b0;
    logic eth_rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   k_seen;

    tx_scheduler_if bus();

    tx_scheduler #(
        .IFG_CYCLES (48),
        .TX_TIMEOUT (1024)
    ) dut (
        .eth_clk   (eth_clk),
        .eth_rst_n (eth_rst_n),
        .bus       (bus)
    );

    always #5 eth_clk = ~eth_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"},   64'(bus.req_ready),   64'd0);
        check({tag, "_tx_start"},    64'(bus.tx_start),    64'd0);
        check({tag, "_timeout_err"}, 64'(bus.timeout_err), 64'd0);
        check({tag, "_tx_payload"},  64'(bus.tx_payload),  64'd0);
        check({tag, "_tx_src"},      64'(bus.tx_src),      64'd0);
        check({tag, "_frames_sent"}, 64'(bus.frames_sent), 64'd0);
        check({tag, "_sched_idle"},  64'(bus.sched_idle),  64'd1);
    endtask

    // Waits (bounded) for tx_start, then compares the granted frame with the scoreboard head.
    task automatic wait_start(input int bound, input string tag);
        exp_t e;
        int   n;
        n = 0;
        do begin
            @(negedge eth_clk);
            n++;
        end while ((bus.tx_start !== 1'b1) && (n < bound));
        check({tag, "_start"}, 64'(bus.tx_start), 64'd1);
        check({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_src"},     64'(bus.tx_src),     64'(e.src));
            check({tag, "_payload"}, 64'(bus.tx_payload), 64'(e.payload));
        end
    endtask

    task automatic finish_frame(input int delay);
        repeat (delay) @(negedge eth_clk);
        bus.tx_done = 1'b1;
        @(negedge eth_clk);
        bus.tx_done = 1'b0;
    endtask

    initial begin
        bus.req_valid    = 2'b00;
        bus.req_payload0 = 44'h0;
        bus.req_payload1 = 44'h0;
        bus.tx_done      = 1'b0;
        eth_rst_n        = 1'b0;
        repeat (3) @(negedge eth_clk);
        check_reset("por");
        eth_rst_n = 1'b1;
        repeat (4) @(negedge eth_clk);

        // Single request from requester 0: same-cycle ready, tx_start one cycle later.
        bus.req_payload0 = P_A;
        bus.req_payload1 = P_B;
        bus.req_valid    = 2'b01;
        #1;
        check("a_ready", 64'(bus.req_ready), 64'd1);
        exp_q.push_back({1'b0, P_A});
        wait_start(1, "a");
        bus.req_valid = 2'b00;
        @(negedge eth_clk);
        check("a_start_one_cycle", 64'(bus.tx_start), 64'd0);
        @(negedge eth_clk);

        // tx_done in cycle T with requester 1 waiting: ready low to T+48, high at T+49.
        bus.tx_done   = 1'b1;
        bus.req_valid = 2'b10;
        exp_q.push_back({1'b1, P_B});
        for (int j = 1; j <= 49; j++) begin
            @(negedge eth_clk);
            bus.tx_done = 1'b0;
            if (j == 1) check("gap_frames", 64'(bus.frames_sent), 64'd1);
            if (j < 49) check("gap_ready_low", 64'(bus.req_ready), 64'd0);
            else        check("gap_ready_high", 64'(bus.req_ready), 64'd2);
        end
        wait_start(1, "b");
        bus.req_valid = 2'b00;
        finish_frame(2);

        // Both requesters held valid over three frames: grants 0, 1, 0.
        bus.req_payload0 = P_C;
        bus.req_payload1 = P_D;
        bus.req_valid    = 2'b11;
        exp_q.push_back({1'b0, P_C});
        exp_q.push_back({1'b1, P_D});
        exp_q.push_back({1'b0, P_C});
        for (int i = 0; i < 3; i++) begin
            wait_start(100, "rr");
            if (i == 2) bus.req_valid = 2'b00;
            finish_frame(3);
        end
        check("rr_frames", 64'(bus.frames_sent), 64'd5);

        // Serializer never answers: timeout 1024 cycles after WAIT_DONE entry.
        bus.req_payload1 = P_E;
        bus.req_valid    = 2'b10;
        exp_q.push_back({1'b1, P_E});
        wait_start(100, "to");
        bus.req_valid = 2'b00;
        k_seen = 0;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge eth_clk);
            if (bus.timeout_err === 1'b1) begin
                k_seen = k;
                break;
            end
        end
        check("to_latency", 64'(k_seen), 64'd1025);
        check("to_frames", 64'(bus.frames_sent), 64'd5);
        check("to_not_idle", 64'(bus.sched_idle), 64'd0);
        bus.tx_done = 1'b1;
        @(negedge eth_clk);
        bus.tx_done = 1'b0;
        check("to_pulse_len", 64'(bus.timeout_err), 64'd0);
        check("to_done_in_gap_ignored", 64'(bus.frames_sent), 64'd5);
        repeat (46) @(negedge eth_clk);
        check("to_gap_end", 64'(bus.sched_idle), 64'd0);
        @(negedge eth_clk);
        check("to_idle", 64'(bus.sched_idle), 64'd1);

        // Counter at 0xFFFF, tx_done coincident with the timeout cycle.
        force dut.frames_sent_r = 16'hFFFF;
        #1;
        release dut.frames_sent_r;
        bus.req_payload0 = P_F;
        bus.req_valid    = 2'b01;
        exp_q.push_back({1'b0, P_F});
        wait_start(5, "co");
        bus.req_valid = 2'b00;
        repeat (1024) @(negedge eth_clk);
        bus.tx_done = 1'b1;
        @(negedge eth_clk);
        bus.tx_done = 1'b0;
        check("co_no_timeout", 64'(bus.timeout_err), 64'd0);
        check("co_frames_wrap", 64'(bus.frames_sent), 64'h0000);
        check("co_in_gap", 64'(bus.sched_idle), 64'd0);
        @(negedge eth_clk);
        check("co_no_timeout_late", 64'(bus.timeout_err), 64'd0);
        repeat (50) @(negedge eth_clk);

        // Reset mid WAIT_DONE: immediate reset values, then requester 0 wins first.
        bus.req_payload0 = P_G;
        bus.req_valid    = 2'b01;
        exp_q.push_back({1'b0, P_G});
        wait_start(5, "pre");
        bus.req_valid = 2'b00;
        repeat (3) @(negedge eth_clk);
        #2;
        eth_rst_n = 1'b0;
        #1;
        check_reset("mid");
        @(negedge eth_clk);
        eth_rst_n = 1'b1;
        repeat (3) @(negedge eth_clk);
        bus.req_payload0 = P_H;
        bus.req_payload1 = P_I;
        bus.req_valid    = 2'b11;
        #1;
        check("rst_ready", 64'(bus.req_ready), 64'd1);
        exp_q.push_back({1'b0, P_H});
        wait_start(1, "rst");
        bus.req_valid = 2'b00;
        finish_frame(2);
        check("rst_frames", 64'(bus.frames_sent), 64'd1);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
